// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_pkg
//  Brief    : Shared helpers for the instruction memory. Lane-address wrap
//             add and even-parity function, used by both write and read paths.
//  Revision : 1.0  initial release
// ============================================================================
package imem_pkg;

    localparam int c_MAX_DATA_W = 256;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    // Word address of a lane, wrapped to an aw-bit address space.
    function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                              input logic [31:0] lane,
                                              input int unsigned aw);
        logic [31:0] mask;
        mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        return (base + lane) & mask;
    endfunction

    // Zero-extension leaves parity unchanged, so one wide function serves all widths.
    function automatic logic even_parity(input logic [c_MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : imem_bank
//  Brief    : Storage array with byte-masked synchronous write and registered
//             FETCH_WIDTH-lane read. Parity column present with IMEM_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module imem_bank
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                              clk0,
    input  logic                              rst0,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH/8-1:0]           wr_be,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] rd_data,
    output logic [FETCH_WIDTH-1:0]            rd_perr
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]             r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0]             w_wr_old;
    logic [DATA_WIDTH-1:0]             w_wr_merged;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] w_rd_word;
    logic [FETCH_WIDTH-1:0]            w_rd_perr;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_rd_data;
    logic [FETCH_WIDTH-1:0]            r_rd_perr;

    assign w_wr_old = r_mem[wr_addr];

    generate
        for (genvar b = 0; b < c_BYTES; b++) begin : g_byte
            assign w_wr_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : w_wr_old[8*b +: 8];
        end
    endgenerate

    always_ff @(posedge clk0) begin
        if (wr_en) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [c_DEPTH];

    // Parity covers the merged word so partial writes stay consistent.
    always_ff @(posedge clk0) begin
        if (wr_en) begin
            r_par[wr_addr] <= even_parity(c_MAX_DATA_W'(w_wr_merged));
        end
    end
`endif

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
            logic [ADDR_WIDTH-1:0] w_addr;
            assign w_addr = ADDR_WIDTH'(lane_addr(32'(rd_addr), 32'(i), ADDR_WIDTH));
            assign w_rd_word[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_addr];
`ifdef IMEM_PARITY_EN
            assign w_rd_perr[i] = even_parity(c_MAX_DATA_W'(r_mem[w_addr])) ^ r_par[w_addr];
`else
            assign w_rd_perr[i] = 1'b0;
`endif
        end
    endgenerate

    // Read registers load only on accept, so a held response ignores later writes.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rd_data <= '0;
            r_rd_perr <= '0;
        end else if (rd_en) begin
            r_rd_data <= w_rd_word;
            r_rd_perr <= w_rd_perr;
        end
    end

    assign rd_data = r_rd_data;
    assign rd_perr = r_rd_perr;

endmodule
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch
//  Brief    : Multi-word instruction memory with valid/ready fetch port,
//             one-cycle latency, byte-masked write port and flush.
//             Optional per-word parity with IMEM_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module imem_fetch
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                              clk0,
    input  logic                              rst0,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0]             rsp_addr,
    output logic [FETCH_WIDTH-1:0]            rsp_perr,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH/8-1:0]           wr_be
);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;

    // Single-port array: a write steals the cycle from any read.
    assign req_ready = !rst0 && !wr_en && !flush && (!rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) w_state_next = c_ST_FULL;
            end
            c_ST_FULL: begin
                if (flush)             w_state_next = c_ST_EMPTY;
                else if (w_accept)     w_state_next = c_ST_FULL;
                else if (rsp_ready)    w_state_next = c_ST_EMPTY;
            end
            default: w_state_next = c_ST_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (r_state == c_ST_FULL);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rsp_addr <= '0;
        end else if (w_accept) begin
            r_rsp_addr <= req_addr;
        end
    end

    assign rsp_addr = r_rsp_addr;

    imem_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_bank (
        .clk0    (clk0),
        .rst0    (rst0),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_en   (w_accept),
        .rd_addr (req_addr),
        .rd_data (rsp_data),
        .rd_perr (rsp_perr)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch
//  Brief    : Directed self-checking bench for imem_fetch (32x256, 2 lanes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_fetch;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_addr;
    logic [1:0]  rsp_perr;
    logic        flush;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk0 = ~clk0;

    imem_fetch #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (8),
        .FETCH_WIDTH (2)
    ) u_dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_perr  (rsp_perr),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be)
    );

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; req_valid = 1'b1; req_addr = 8'd0; rsp_ready = 1'b1;
        flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        tick(); tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'd0) begin n_err++; $display("FAIL reset_rsp_addr: got %h want 0", rsp_addr); end
        n_cmp++; if (rsp_perr !== 2'b00) begin n_err++; $display("FAIL reset_rsp_perr: got %b want 00", rsp_perr); end
        req_valid = 1'b0;
        rst0 = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_write(8'd0, 32'h003100b3, 4'hF);
        do_write(8'd1, 32'h40208133, 4'hF);
        do_write(8'd2, 32'h00000013, 4'hF);
        req_valid = 1'b1; req_addr = 8'd0; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL basic_req_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_rsp_valid: got %0b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h40208133_003100b3) begin n_err++; $display("FAIL basic_rsp_data: got %h want 40208133003100b3", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'd0) begin n_err++; $display("FAIL basic_rsp_addr: got %h want 00", rsp_addr); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_wrap();
        do_write(8'd255, 32'hAAAA0001, 4'hF);
        do_write(8'd0,   32'hBBBB0002, 4'hF);
        req_valid = 1'b1; req_addr = 8'd255; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_data !== 64'hBBBB0002_AAAA0001) begin n_err++; $display("FAIL wrap_rsp_data: got %h want BBBB0002AAAA0001", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_rsp_addr: got %h want ff", rsp_addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_addr = 8'd1; rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rsp_data !== 64'h00000013_40208133) begin n_err++; $display("FAIL b2b_first_data: got %h want 0000001340208133", rsp_data); end
        req_addr = 8'd0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %0b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h40208133_BBBB0002) begin n_err++; $display("FAIL b2b_second_data: got %h want 40208133BBBB0002", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'd0) begin n_err++; $display("FAIL b2b_second_addr: got %h want 00", rsp_addr); end
    endtask

    // Entered with a valid response for addr 0 still held.
    task automatic test_backpressure();
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd255;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                wr_en = 1'b1; wr_addr = 8'd0; wr_data = 32'hCCCC0003; wr_be = 4'hF;
            end
            #1;
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %0b want 0", k, req_ready); end
            tick();
            wr_en = 1'b0;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid[%0d]: got %0b want 1", k, rsp_valid); end
            n_cmp++; if (rsp_data !== 64'h40208133_BBBB0002) begin n_err++; $display("FAIL bp_rsp_data[%0d]: got %h want 40208133BBBB0002", k, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_data !== 64'hCCCC0003_AAAA0001) begin n_err++; $display("FAIL bp_release_data: got %h want CCCC0003AAAA0001", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'hFF) begin n_err++; $display("FAIL bp_release_addr: got %h want ff", rsp_addr); end
    endtask

    task automatic test_collision();
        do_write(8'd5, 32'h00500005, 4'hF);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL coll_consumed: got %0b want 0", rsp_valid); end
        wr_en = 1'b1; wr_addr = 8'd4; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        req_valid = 1'b1; req_addr = 8'd4;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL coll_req_ready: got %0b want 0", req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL coll_no_accept: got %0b want 0", rsp_valid); end
        wr_data = 32'h12345678; wr_be = 4'b0011;
        tick();
        wr_en = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready_after: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_data !== 64'h00500005_FFFF5678) begin n_err++; $display("FAIL coll_merged_data: got %h want 00500005FFFF5678", rsp_data); end
    endtask

    // Entered with a valid response for addr 4.
    task automatic test_flush();
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0; flush = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd6; wr_data = 32'h66666666; wr_be = 4'hF;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_req_ready: got %0b want 0", req_ready); end
        tick();
        flush = 1'b0; wr_en = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_rsp_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_addr !== 8'd4) begin n_err++; $display("FAIL flush_not_accepted: got %h want 04", rsp_addr); end
        req_addr = 8'd6;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_data[31:0] !== 32'h66666666) begin n_err++; $display("FAIL flush_write_kept: got %h want 66666666", rsp_data[31:0]); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_refetch_valid: got %0b want 1", rsp_valid); end
    endtask

    // Entered with a held response; reset must drop it.
    task automatic test_reset_mid();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", rsp_data); end
        n_cmp++; if (rsp_addr !== 8'd0) begin n_err++; $display("FAIL rstmid_addr: got %h want 00", rsp_addr); end
        rsp_ready = 1'b1;
    endtask

    task automatic test_parity();
        do_write(8'd3, 32'h0000_00F1, 4'hF);
        do_write(8'd4, 32'h1234_5678, 4'hF);
`ifdef IMEM_PARITY_EN
        u_dut.u_bank.r_mem[3][0] = ~u_dut.u_bank.r_mem[3][0];
`endif
        req_valid = 1'b1; req_addr = 8'd3; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
`ifdef IMEM_PARITY_EN
        n_cmp++; if (rsp_perr !== 2'b01) begin n_err++; $display("FAIL parity_perr: got %b want 01", rsp_perr); end
`else
        n_cmp++; if (rsp_perr !== 2'b00) begin n_err++; $display("FAIL parity_perr: got %b want 00", rsp_perr); end
        n_cmp++; if (rsp_data !== 64'h12345678_000000F1) begin n_err++; $display("FAIL parity_data: got %h want 12345678000000F1", rsp_data); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_collision();
        test_flush();
        test_reset_mid();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory for the out-of-order front end. It returns FETCH_WIDTH consecutive instruction words per access through a valid/ready request/response pair with one-cycle latency. A byte-masked write port loads programs, and a flush input kills the in-flight response on redirect. It replaces the single-word OpenRAM-style imem between the fetch unit and the decode/rename queue.

## Interface
- DATA_WIDTH, 32: bits per instruction word (multiple of 8)
- ADDR_WIDTH, 8: word-address bits; depth = 2**ADDR_WIDTH
- FETCH_WIDTH, 2: words returned per access (1..8)
- clk0  in  1  clock; all logic on rising edge
- rst0  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_addr  in  ADDR_WIDTH  word address of lane 0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer takes response
- rsp_data  out  FETCH_WIDTH*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_addr  out  ADDR_WIDTH  req_addr of the returned access
- rsp_perr  out  FETCH_WIDTH  per-lane parity error (see Configuration)
- flush  in  1  discard pending response, block new request this cycle
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write word address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables, bit b covers bits [8b+7:8b]

## Operation
- Lane i reads word (req_addr + i) mod 2**ADDR_WIDTH; wrap-around at top of memory is silent, all lanes valid.
- req_ready = !rst0 && !wr_en && !flush && (!rsp_valid || rsp_ready). Combinational, no dependence on req_valid.
- Accepted request: rsp_data, rsp_addr, rsp_perr load at that edge; rsp_valid set.
- Held response: rsp_valid && !rsp_ready keeps rsp_data/rsp_addr/rsp_perr stable. Later writes do not alter held data.
- Response consumed with no new accept: rsp_valid clears next edge.
- Write: wr_en at edge writes enabled bytes of mem[wr_addr]. Write has priority over read; a single-port array gives one access per cycle. Writes proceed regardless of rsp_valid or flush.
- Flush: at edge with flush=1, rsp_valid clears; no request accepted that cycle; a concurrent write still happens.
- Reset: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_perr=0. req_ready=0 while rst0 is high. Memory contents are not reset (undefined until written). Reset mid-response drops it.
- No state machine beyond the one-entry output register: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with rsp_ready, or on stall.
  - FULL→EMPTY on rsp_ready without accept, on flush, or on rst0.

## Timing
- Read latency 1: request accepted at edge N, data valid after edge N. Back-to-back accepts give one response per cycle.
- Write-then-read: a write at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- rsp_* are registered outputs. req_ready is combinational from wr_en, flush, rsp_valid, rsp_ready and rst0.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed per byte-merged write.
  - rsp_perr[i] = 1 when lane i's stored parity mismatches its data.
  - A partial write recomputes parity over the merged word.
- Undefined: no parity storage; rsp_perr tied to 0.

## Structure
- Package imem_pkg: lane-address helper function (wrap add) and parity function. The parity function is needed in both the write and read paths.
- Sub-module imem_bank: the storage array with byte-masked synchronous write and synchronous multi-lane read, plus the parity column when enabled. imem_fetch holds the handshake/flush/output-register logic.

## Test plan
- Reset, then write 0x003100b3 to addr 0 and 0x40208133 to addr 1; request addr 0 (FETCH_WIDTH=2) → next cycle rsp_valid=1, rsp_data = {0x40208133, 0x003100b3}, rsp_addr=0.
- Wrap-around: write 0xAAAA0001 at 255 and 0xBBBB0002 at 0; request addr 255 → lane0 = 0xAAAA0001, lane1 = 0xBBBB0002.
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_data unchanged. Release → the next request is accepted on that edge.
- Write collision: wr_en=1 and req_valid=1 in the same cycle → req_ready=0. Write 0x12345678 with wr_be=4'b0011 over 0xFFFFFFFF → stored 0xFFFF5678, readable next cycle.
- Flush: while rsp_valid=1 and rsp_ready=0, pulse flush → rsp_valid=0 next edge. A request in the flush cycle is not accepted.
- With IMEM_PARITY_EN: force a single data-bit flip in the array at addr 3, then read → rsp_perr[0]=1 and other lanes 0. Without the macro, rsp_perr stays 0.
